// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, resolves ALU operands with
// EX/MEM and MEM/WB forwarding, and detects load-use hazards.
module id_ex_stage #(
  parameter int DATA_SIZE     = 32,
  parameter int ALU_CTRL_SIZE = 4,
  parameter int REG_ADDR_SIZE = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [DATA_SIZE-1:0]     id_pc,
  input  logic [DATA_SIZE-1:0]     id_rs1_data,
  input  logic [DATA_SIZE-1:0]     id_rs2_data,
  input  logic [REG_ADDR_SIZE-1:0] id_rs1_addr,
  input  logic [REG_ADDR_SIZE-1:0] id_rs2_addr,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic [DATA_SIZE-1:0]     id_imm,
  input  logic [REG_ADDR_SIZE-1:0] id_rd_addr,
  input  logic [ALU_CTRL_SIZE-1:0] id_alu_ctrl,
  input  logic                     id_src_a_sel,
  input  logic                     id_src_b_sel,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     stall_in,
  input  logic                     flush,
  input  logic                     exmem_reg_write,
  input  logic [REG_ADDR_SIZE-1:0] exmem_rd_addr,
  input  logic [DATA_SIZE-1:0]     exmem_result,
  input  logic                     memwb_reg_write,
  input  logic [REG_ADDR_SIZE-1:0] memwb_rd_addr,
  input  logic [DATA_SIZE-1:0]     memwb_result,
  output logic                     load_use_stall,
  output logic                     ex_valid,
  output logic [DATA_SIZE-1:0]     ex_A,
  output logic [DATA_SIZE-1:0]     ex_B,
  output logic [ALU_CTRL_SIZE-1:0] ex_alu_ctrl,
  output logic [DATA_SIZE-1:0]     ex_store_data,
  output logic [REG_ADDR_SIZE-1:0] ex_rd_addr,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write
);

  logic [DATA_SIZE-1:0]     pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [REG_ADDR_SIZE-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [ALU_CTRL_SIZE-1:0] alu_ctrl_q;
  logic                     valid_q, uses_rs1_q, uses_rs2_q, src_a_sel_q, src_b_sel_q;
  logic                     reg_write_q, mem_read_q, mem_write_q;
  logic                     bubble, capture;
  logic [DATA_SIZE-1:0]     rs1_fwd, rs2_fwd;

  // Stall handshake: stall_in freezes this register (a flush still wins);
  // load_use_stall asks upstream to hold PC and IF/ID while a bubble goes in.
  assign load_use_stall = valid_q && mem_read_q && (rd_addr_q != '0) && id_valid &&
                          ((id_uses_rs1 && (id_rs1_addr == rd_addr_q)) ||
                           (id_uses_rs2 && (id_rs2_addr == rd_addr_q)));

  assign bubble  = flush || (!stall_in && (load_use_stall || !id_valid));
  assign capture = !stall_in;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      uses_rs1_q  <= 1'b0;
      uses_rs2_q  <= 1'b0;
      imm_q       <= '0;
      rd_addr_q   <= '0;
      alu_ctrl_q  <= '0;
      src_a_sel_q <= 1'b0;
      src_b_sel_q <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (capture) begin
      valid_q     <= 1'b1;
      pc_q        <= id_pc;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      rs1_addr_q  <= id_rs1_addr;
      rs2_addr_q  <= id_rs2_addr;
      uses_rs1_q  <= id_uses_rs1;
      uses_rs2_q  <= id_uses_rs2;
      imm_q       <= id_imm;
      rd_addr_q   <= id_rd_addr;
      alu_ctrl_q  <= id_alu_ctrl;
      src_a_sel_q <= id_src_a_sel;
      src_b_sel_q <= id_src_b_sel;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
      mem_write_q <= id_mem_write;
    end
  end

  // EX/MEM is the younger producer, so it beats MEM/WB; x0 is never forwarded.
  function automatic logic [DATA_SIZE-1:0] resolve(
    input logic                     uses,
    input logic [REG_ADDR_SIZE-1:0] addr,
    input logic [DATA_SIZE-1:0]     rf_data,
    input logic                     xm_we,
    input logic [REG_ADDR_SIZE-1:0] xm_rd,
    input logic [DATA_SIZE-1:0]     xm_res,
    input logic                     mw_we,
    input logic [REG_ADDR_SIZE-1:0] mw_rd,
    input logic [DATA_SIZE-1:0]     mw_res
  );
    logic [DATA_SIZE-1:0] r;
    r = rf_data;
    if (uses && xm_we && (xm_rd != '0) && (xm_rd == addr))
      r = xm_res;
    else if (uses && mw_we && (mw_rd != '0) && (mw_rd == addr))
      r = mw_res;
    return r;
  endfunction

  always_comb begin
    rs1_fwd = resolve(uses_rs1_q, rs1_addr_q, rs1_data_q,
                      exmem_reg_write, exmem_rd_addr, exmem_result,
                      memwb_reg_write, memwb_rd_addr, memwb_result);
    rs2_fwd = resolve(uses_rs2_q, rs2_addr_q, rs2_data_q,
                      exmem_reg_write, exmem_rd_addr, exmem_result,
                      memwb_reg_write, memwb_rd_addr, memwb_result);
  end

  assign ex_A          = src_a_sel_q ? pc_q  : rs1_fwd;
  assign ex_B          = src_b_sel_q ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ex_valid      = valid_q;
  assign ex_alu_ctrl   = alu_ctrl_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written hazard/flush/stall
// sequences, and randomized traffic against an instruction-slot reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_uses_rs1, id_uses_rs2;
  logic [3:0]  id_alu_ctrl;
  logic        id_src_a_sel, id_src_b_sel;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        stall_in, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_result, memwb_result;
  logic        load_use_stall, ex_valid;
  logic [31:0] ex_A, ex_B, ex_store_data;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_imm(id_imm), .id_rd_addr(id_rd_addr), .id_alu_ctrl(id_alu_ctrl),
    .id_src_a_sel(id_src_a_sel), .id_src_b_sel(id_src_b_sel),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall_in(stall_in), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_alu_ctrl = 0; id_src_a_sel = 0; id_src_b_sel = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    stall_in = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 0;
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom_range(0, 3) != 0);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
    id_rd_addr = 5'($urandom_range(0, 7));
    id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
    id_alu_ctrl = 4'($urandom_range(0, 11));
    id_src_a_sel = 1'($urandom); id_src_b_sel = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = 1'($urandom_range(0, 2) == 0);
    id_mem_write = 1'($urandom);
  endtask

  task automatic rand_fwd();
    exmem_reg_write = 1'($urandom); exmem_rd_addr = 5'($urandom_range(0, 7)); exmem_result = $urandom;
    memwb_reg_write = 1'($urandom); memwb_rd_addr = 5'($urandom_range(0, 7)); memwb_result = $urandom;
  endtask

  // advance one edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: the instruction sitting in EX ----------------
  typedef struct {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  a1, a2, rd;
    logic        u1, u2, asel, bsel, rw, mr, mw;
    logic [3:0]  ctrl;
  } slot_t;

  slot_t m, m_next, empty_slot;

  // value a source register holds as seen by the ALU right now
  function automatic logic [31:0] value_of(input logic used, input logic [4:0] r, input logic [31:0] rf);
    if (!used || r == 0) return rf;
    if (exmem_reg_write && exmem_rd_addr == r) return exmem_result;
    if (memwb_reg_write && memwb_rd_addr == r) return memwb_result;
    return rf;
  endfunction

  function automatic logic model_hazard();
    logic reads;
    reads = (id_uses_rs1 && id_rs1_addr == m.rd) || (id_uses_rs2 && id_rs2_addr == m.rd);
    return m.valid && m.mr && m.rd != 0 && id_valid && reads;
  endfunction

  function automatic slot_t decode_slot();
    slot_t s;
    s.valid = 1; s.pc = id_pc; s.d1 = id_rs1_data; s.d2 = id_rs2_data; s.imm = id_imm;
    s.a1 = id_rs1_addr; s.a2 = id_rs2_addr; s.rd = id_rd_addr;
    s.u1 = id_uses_rs1; s.u2 = id_uses_rs2; s.asel = id_src_a_sel; s.bsel = id_src_b_sel;
    s.rw = id_reg_write; s.mr = id_mem_read; s.mw = id_mem_write; s.ctrl = id_alu_ctrl;
    return s;
  endfunction

  task automatic compare_model(input string tag);
    logic [31:0] v1, v2;
    v1 = value_of(m.u1, m.a1, m.d1);
    v2 = value_of(m.u2, m.a2, m.d2);
    check({tag, ".A"}, ex_A, m.asel ? m.pc : v1);
    check({tag, ".B"}, ex_B, m.bsel ? m.imm : v2);
    check({tag, ".store"}, ex_store_data, v2);
    check({tag, ".ctrl"}, {27'd0, ex_alu_ctrl, ex_valid}, {27'd0, m.ctrl, m.valid});
    check({tag, ".rd"}, {24'd0, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write},
                        {24'd0, m.rd, m.rw, m.mr, m.mw});
    check({tag, ".lus"}, {31'd0, load_use_stall}, {31'd0, model_hazard()});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0]  a1; logic [31:0] d1; logic u1;
    logic [4:0]  a2; logic [31:0] d2; logic u2;
    logic [31:0] pc, imm; logic asel, bsel; logic [3:0] ctrl;
    logic xw; logic [4:0] xrd; logic [31:0] xres;
    logic ww; logic [4:0] wrd; logic [31:0] wres;
    logic [31:0] exp_a, exp_b, exp_st;
  } vec_t;

  vec_t vecs[8];

  initial begin
    empty_slot = '{valid: 0, pc: 0, d1: 0, d2: 0, imm: 0, a1: 0, a2: 0, rd: 0,
                   u1: 0, u2: 0, asel: 0, bsel: 0, rw: 0, mr: 0, mw: 0, ctrl: 0};
    //         a1 d1            u1 a2 d2     u2 pc       imm      as bs ctrl  xw xrd xres     ww wrd wres     expA     expB     expSt
    vecs[0] = '{1, 32'h10,   1, 0, 32'h77, 0, 32'h0,   32'h5,   0, 1, 4'd2, 0, 0, 32'h0,    0, 0, 32'h0,    32'h10,   32'h5,    32'h77};
    vecs[1] = '{3, 32'h1234, 1, 0, 32'h0,  0, 32'h0,   32'h0,   0, 1, 4'd2, 1, 3, 32'hAAAA, 1, 3, 32'hBBBB, 32'hAAAA, 32'h0,    32'h0};
    vecs[2] = '{3, 32'h1234, 1, 0, 32'h0,  0, 32'h0,   32'h0,   0, 1, 4'd2, 0, 3, 32'hAAAA, 1, 3, 32'hBBBB, 32'hBBBB, 32'h0,    32'h0};
    vecs[3] = '{0, 32'h1234, 1, 0, 32'h0,  0, 32'h0,   32'h0,   0, 1, 4'd2, 1, 0, 32'hAAAA, 1, 0, 32'hBBBB, 32'h1234, 32'h0,    32'h0};
    vecs[4] = '{0, 32'h0,    0, 0, 32'h0,  0, 32'h1000,32'h2000,1, 1, 4'd2, 0, 0, 32'h0,    0, 0, 32'h0,    32'h1000, 32'h2000, 32'h0};
    vecs[5] = '{2, 32'h100,  1, 4, 32'h9,  1, 32'h0,   32'h8,   0, 1, 4'd2, 1, 4, 32'h55,   0, 0, 32'h0,    32'h100,  32'h8,    32'h55};
    vecs[6] = '{6, 32'h66,   0, 0, 32'h0,  0, 32'h0,   32'h0,   0, 0, 4'd6, 1, 6, 32'hEE,   0, 0, 32'h0,    32'h66,   32'h0,    32'h0};
    vecs[7] = '{1, 32'h3,    1, 7, 32'h1,  1, 32'h0,   32'h0,   0, 0, 4'd11,1, 2, 32'h99,   1, 7, 32'hCAFE, 32'h3,    32'hCAFE, 32'hCAFE};

    idle();
    rst = 1;

    // ---- reset with random decode inputs ----
    rand_id();
    tick();
    rand_id();
    tick();
    check("rst.valid", {31'd0, ex_valid}, 0);
    check("rst.reg_write", {31'd0, ex_reg_write}, 0);
    check("rst.mem_read", {31'd0, ex_mem_read}, 0);
    check("rst.alu_ctrl", {28'd0, ex_alu_ctrl}, 0);
    check("rst.lus", {31'd0, load_use_stall}, 0);
    idle();
    rst = 0;
    tick();

    // ---- vector table ----
    for (int i = 0; i < 8; i++) begin
      idle();
      id_valid = 1; id_reg_write = 1; id_rd_addr = 5'd1;
      id_rs1_addr = vecs[i].a1; id_rs1_data = vecs[i].d1; id_uses_rs1 = vecs[i].u1;
      id_rs2_addr = vecs[i].a2; id_rs2_data = vecs[i].d2; id_uses_rs2 = vecs[i].u2;
      id_pc = vecs[i].pc; id_imm = vecs[i].imm;
      id_src_a_sel = vecs[i].asel; id_src_b_sel = vecs[i].bsel; id_alu_ctrl = vecs[i].ctrl;
      tick();
      exmem_reg_write = vecs[i].xw; exmem_rd_addr = vecs[i].xrd; exmem_result = vecs[i].xres;
      memwb_reg_write = vecs[i].ww; memwb_rd_addr = vecs[i].wrd; memwb_result = vecs[i].wres;
      #1;
      check($sformatf("vec%0d.A", i), ex_A, vecs[i].exp_a);
      check($sformatf("vec%0d.B", i), ex_B, vecs[i].exp_b);
      check($sformatf("vec%0d.store", i), ex_store_data, vecs[i].exp_st);
      check($sformatf("vec%0d.ctrl", i), {28'd0, ex_alu_ctrl}, {28'd0, vecs[i].ctrl});
      check($sformatf("vec%0d.valid", i), {31'd0, ex_valid}, 1);
    end

    // ---- load-use: LW x5 then ADD reading x5 ----
    idle();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd_addr = 5'd5; id_src_b_sel = 1;
    tick();
    idle();
    id_valid = 1; id_reg_write = 1; id_rd_addr = 5'd8; id_alu_ctrl = 4'd2;
    id_uses_rs1 = 1; id_rs1_addr = 5'd5; id_rs1_data = 32'h0;
    id_uses_rs2 = 1; id_rs2_addr = 5'd6; id_rs2_data = 32'h3;
    #1;
    check("lu.stall", {31'd0, load_use_stall}, 1);
    tick();
    check("lu.bubble_valid", {31'd0, ex_valid}, 0);
    check("lu.bubble_rw", {31'd0, ex_reg_write}, 0);
    check("lu.stall_clear", {31'd0, load_use_stall}, 0);
    tick();
    memwb_reg_write = 1; memwb_rd_addr = 5'd5; memwb_result = 32'hDEAD;
    #1;
    check("lu.add_valid", {31'd0, ex_valid}, 1);
    check("lu.add_A", ex_A, 32'hDEAD);
    check("lu.add_B", ex_B, 32'h3);

    // ---- stall_in holds for 3 cycles ----
    idle();
    id_valid = 1; id_reg_write = 1; id_rd_addr = 5'd9; id_alu_ctrl = 4'd6;
    id_uses_rs1 = 1; id_rs1_addr = 5'd1; id_rs1_data = 32'h11;
    id_uses_rs2 = 1; id_rs2_addr = 5'd2; id_rs2_data = 32'h22;
    tick();
    stall_in = 1;
    for (int k = 0; k < 3; k++) begin
      rand_id();
      tick();
      check($sformatf("hold%0d.A", k), ex_A, 32'h11);
      check($sformatf("hold%0d.B", k), ex_B, 32'h22);
      check($sformatf("hold%0d.store", k), ex_store_data, 32'h22);
      check($sformatf("hold%0d.ctrl", k), {28'd0, ex_alu_ctrl}, 32'd6);
      check($sformatf("hold%0d.rd", k), {24'd0, ex_rd_addr, ex_valid, ex_reg_write, ex_mem_read},
                                         {24'd0, 5'd9, 1'b1, 1'b1, 1'b0});
    end

    // ---- flush together with stall_in gives a bubble ----
    flush = 1;
    tick();
    check("flush_stall.valid", {31'd0, ex_valid}, 0);
    check("flush_stall.rw", {31'd0, ex_reg_write}, 0);

    // ---- capture with id_valid=0 forces control flags off ----
    idle();
    id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_rd_addr = 5'd4;
    tick();
    check("invalid.flags", {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, 0);

    // ---- randomized traffic against the slot model ----
    m = empty_slot;
    for (int c = 0; c < 600; c++) begin
      rand_id();
      rand_fwd();
      stall_in = 1'($urandom_range(0, 7) == 0);
      flush = 1'($urandom_range(0, 9) == 0);
      #1;
      compare_model($sformatf("rnd%0d", c));
      if (flush) m_next = empty_slot;
      else if (stall_in) m_next = m;
      else if (model_hazard() || !id_valid) m_next = empty_slot;
      else m_next = decode_slot();
      @(posedge clk);
      m = m_next;
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the decode stage and the ALU.
- Captures decoded instruction fields each cycle and resolves ALU operands A/B in the EX cycle, with forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards: stalls upstream and inserts a bubble.
- Outputs drive the ALU's A, B and Control inputs directly.

Parameters:
- DATA_SIZE, 32, datapath width (matches `data_size`).
- ALU_CTRL_SIZE, 4, ALU control width (matches `alu_control_size`).
- REG_ADDR_SIZE, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  DATA_SIZE  instruction PC.
- id_rs1_data, id_rs2_data  in  DATA_SIZE  register-file read data.
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_SIZE  source indices.
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2.
- id_imm  in  DATA_SIZE  sign-extended immediate; LUI gets the raw U-immediate.
- id_rd_addr  in  REG_ADDR_SIZE  destination index.
- id_alu_ctrl  in  ALU_CTRL_SIZE  ALU opcode, S0..S11 encoding.
- id_src_a_sel  in  1  0=rs1, 1=PC (AUIPC).
- id_src_b_sel  in  1  0=rs2, 1=imm.
- id_reg_write, id_mem_read, id_mem_write  in  1  control flags.
- stall_in  in  1  downstream hold request.
- flush  in  1  kill the instruction entering EX (branch/jump redirect).
- exmem_reg_write, exmem_rd_addr, exmem_result  in  1/REG_ADDR_SIZE/DATA_SIZE  EX/MEM forwarding source.
- memwb_reg_write, memwb_rd_addr, memwb_result  in  1/REG_ADDR_SIZE/DATA_SIZE  MEM/WB forwarding source.
- load_use_stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX slot valid.
- ex_A, ex_B  out  DATA_SIZE  resolved ALU operands.
- ex_alu_ctrl  out  ALU_CTRL_SIZE  to ALU Control.
- ex_store_data  out  DATA_SIZE  forwarded rs2 value, for stores.
- ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write  out  registered control.

Behaviour:
- Reset (rst=1 at edge): all registered fields cleared to 0. ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, ex_alu_ctrl=0, ex_rd_addr=0. ex_A/ex_B/ex_store_data then evaluate from zeroed fields.
- Latency: decode fields appear on ex_* one cycle after capture. Operand resolution is combinational in the EX cycle, from the registered fields and the current forwarding buses.
- Forwarding for each source rsN, using the registered rsN address and uses flag:
  - If uses=1, exmem_reg_write=1, exmem_rd_addr!=0 and exmem_rd_addr==rsN: use exmem_result.
  - Else, if the same conditions hold for memwb: use memwb_result.
  - Else: use the registered register-file data.
  - EX/MEM always has priority over MEM/WB. Register x0 is never forwarded.
- Operand selection:
  - ex_A = PC if src_a_sel=1, else forwarded rs1.
  - ex_B = imm if src_b_sel=1, else forwarded rs2.
  - ex_store_data = forwarded rs2, regardless of src_b_sel.
- load_use_stall (combinational) = ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
- Register update priority at each edge, highest first:
  - rst: clear.
  - flush: bubble.
  - stall_in: hold all fields.
  - load_use_stall: bubble.
  - Otherwise: capture the id_* inputs.
- Bubble: ex_valid, reg_write, mem_read and mem_write all 0; other fields are don't-care but are cleared.
- flush together with stall_in gives a bubble. A flush must never be lost.
- Capturing with id_valid=0 gives a bubble, with control flags forced to 0.

Test Plan:
- Reset: hold rst for 2 cycles with random id_* inputs -> ex_valid=0, ex_reg_write=0, ex_alu_ctrl=0, load_use_stall=0.
- Plain pass: ADDI with rs1 data=0x10, imm=0x5, ctrl=4'b0010, no forwarding match -> next cycle ex_A=0x10, ex_B=0x5, ex_alu_ctrl=4'b0010, ex_valid=1.
- Forward priority: EX rs1=x3; exmem rd=x3 result=0xAAAA and memwb rd=x3 result=0xBBBB, both reg_write=1 -> ex_A=0xAAAA. Drop exmem_reg_write -> ex_A=0xBBBB. rs1=x0 with both matching x0 -> ex_A=registered data.
- Load-use: EX holds LW to x5; ID has ADD reading x5 -> load_use_stall=1; next cycle ex_valid=0. Following cycle ADD enters and ex_A takes memwb_result.
- Flush vs stall: flush=1 and stall_in=1 in the same cycle -> next ex_valid=0. With stall_in alone, all ex_* outputs hold for 3 cycles unchanged.
- AUIPC/store: src_a_sel=1, PC=0x1000, imm=0x2000 -> ex_A=0x1000, ex_B=0x2000. SW with rs2 matching exmem result 0x55 -> ex_store_data=0x55, ex_B=imm.
